// File: rtl/image_write_pkg.sv
// image_write_pkg: FSM states, BMP constants and header byte generator shared by the image reader and writer
package image_pkg;

   typedef enum logic [1:0] {ST_CAPTURE, ST_HEADER, ST_PIXELS, ST_DONE} state_t;

   localparam int BMP_HDR_BYTES = 54;

   // Header fields are 32-bit little-endian words on a 4-byte grid starting at byte 2;
   // planes (1) and bpp (24) share the word at byte 26.
   function automatic logic [7:0] bmp_hdr_byte(input int idx, input int width, input int height);
      int img;
      int base;
      logic [31:0] v;
      img  = width * height * 3;
      base = ((idx - 2) / 4) * 4 + 2;
      v = base == 2  ? 54 + img :
          base == 10 ? 54 :
          base == 14 ? 40 :
          base == 18 ? width :
          base == 22 ? height :
          base == 26 ? 32'h0018_0001 :
          base == 34 ? img : 0;
      return idx == 0 ? 8'h42 : idx == 1 ? 8'h4D : 8'(v >> (8 * (idx - base)));
   endfunction

endpackage

// File: rtl/image_write_frame_buf.sv
// frame_buf: frame store written one pixel pair (6 bytes) per clock, read one byte per clock
module frame_buf #(
   parameter int DEPTH = 768 * 512 * 3,
   parameter int AW    = $clog2(DEPTH / 6 + 1)
) (
   input  logic          HCLK,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [47:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   input  logic [2:0]    rd_lane,
   output logic [7:0]    rd_data
);

   // Byte address = 6 * word + lane; pairs are always 6-byte aligned so one wide word holds a pair.
   logic [47:0] mem [DEPTH / 6];
   logic [47:0] rd_q;
   logic [2:0]  lane_q;

   // Pair write and registered word read; lane select follows the read register
   always_ff @(posedge HCLK) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) begin
         rd_q   <= mem[rd_addr];
         lane_q <= rd_lane;
      end
   end

   assign rd_data = 8'(rd_q >> {lane_q, 3'b000});

endmodule

// File: rtl/image_write.sv
// image_write: captures one HSYNC-qualified pixel-pair frame and streams it out as a 24-bit BMP file
module image_write
   import image_pkg::*;
#(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       VSYNC,
   input  logic       HSYNC,
   input  logic [7:0] DATA_R0,
   input  logic [7:0] DATA_G0,
   input  logic [7:0] DATA_B0,
   input  logic [7:0] DATA_R1,
   input  logic [7:0] DATA_G1,
   input  logic [7:0] DATA_B1,
   output logic [7:0] out_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       write_done,
   output logic       drop_err
);

   localparam int NPAIRS = WIDTH * HEIGHT / 2;
   localparam int TOTAL  = BMP_HDR_BYTES + WIDTH * HEIGHT * 3;
   localparam int IW     = $clog2(TOTAL + 1);
   localparam int AW     = $clog2(NPAIRS + 1);
   localparam int CW     = $clog2(WIDTH);
   localparam int RW     = $clog2(HEIGHT + 1);
   localparam int PW     = $clog2(NPAIRS + 1);

   if (WIDTH % 2 != 0 || (WIDTH * 3) % 4 != 0) begin : g_bad_width
      $error("image_write: WIDTH must be even and WIDTH*3 a multiple of 4 (no row padding)");
   end

   state_t          st;
   logic            vs_q;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic [PW-1:0]   pair_cnt;
   logic [IW-1:0]   idx;
   logic [AW-1:0]   rd_word;
   logic [2:0]      rd_lane;
   logic            pend, pend_hdr, pend_last;
   logic [7:0]      hdr_q, ram_byte, sp_byte;
   logic            sp_v, sp_last;
   logic            vs_rise, restart, cap, cap_last, col_wrap, pop, room, issue, is_hdr, rd_en;
   logic [CW-1:0]   eff_col;
   logic [RW-1:0]   eff_row;
   logic [PW-1:0]   eff_cnt;
   logic [AW-1:0]   wr_addr;
   logic [7:0]      in_byte;

   // A VSYNC rise in capture restarts the frame; a pair in that same cycle lands as pair 0.
   always_comb begin
      vs_rise  = VSYNC & ~vs_q;
      restart  = st == ST_CAPTURE && vs_rise;
      eff_col  = restart ? '0 : col;
      eff_row  = restart ? '0 : row;
      eff_cnt  = restart ? '0 : pair_cnt;
      cap      = st == ST_CAPTURE && HSYNC;
      cap_last = cap && eff_cnt == PW'(NPAIRS - 1);
      col_wrap = eff_col == CW'(WIDTH - 2);
      wr_addr  = AW'(HEIGHT - 1 - int'(eff_row)) * AW'(WIDTH / 2) + AW'(eff_col >> 1);
      pop      = out_valid && out_ready;
      room     = 2'(out_valid) + 2'(sp_v) + 2'(pend) - 2'(pop) < 2'd2;
      issue    = room && idx != IW'(TOTAL) && (cap_last || st == ST_HEADER || st == ST_PIXELS);
      is_hdr   = idx < IW'(BMP_HDR_BYTES);
      rd_en    = issue && !is_hdr;
      in_byte  = pend_hdr ? hdr_q : ram_byte;
   end

   frame_buf #(.DEPTH(WIDTH * HEIGHT * 3), .AW(AW)) u_buf (
      .HCLK    (HCLK),
      .wr_en   (cap),
      .wr_addr (wr_addr),
      .wr_data ({DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0}),
      .rd_en   (rd_en),
      .rd_addr (rd_word),
      .rd_lane (rd_lane),
      .rd_data (ram_byte)
   );

   // FSM, capture counters and byte issue; header bytes are registered so every source has 1-cycle latency
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         st         <= ST_CAPTURE;
         vs_q       <= 1'b0;
         col        <= '0;
         row        <= '0;
         pair_cnt   <= '0;
         idx        <= '0;
         rd_word    <= '0;
         rd_lane    <= '0;
         pend       <= 1'b0;
         pend_hdr   <= 1'b0;
         pend_last  <= 1'b0;
         hdr_q      <= '0;
         write_done <= 1'b0;
         drop_err   <= 1'b0;
      end else begin
         vs_q      <= VSYNC;
         pend      <= issue;
         pend_hdr  <= is_hdr;
         pend_last <= idx == IW'(TOTAL - 1);
         if (HSYNC && st != ST_CAPTURE) drop_err <= 1'b1;
         if (issue && is_hdr) hdr_q <= bmp_hdr_byte(int'(idx), WIDTH, HEIGHT);
         if (issue) idx <= idx + IW'(1);
         if (rd_en) begin
            rd_lane <= rd_lane == 3'd5 ? 3'd0 : rd_lane + 3'd1;
            rd_word <= rd_lane == 3'd5 ? rd_word + AW'(1) : rd_word;
         end
         if (st == ST_CAPTURE) begin
            col      <= cap ? (col_wrap ? '0 : eff_col + CW'(2)) : eff_col;
            row      <= cap && col_wrap ? eff_row + RW'(1) : eff_row;
            pair_cnt <= cap ? eff_cnt + PW'(1) : eff_cnt;
            if (cap_last) st <= ST_HEADER;
         end else if (st == ST_HEADER) begin
            if (issue && idx == IW'(BMP_HDR_BYTES - 1)) st <= ST_PIXELS;
         end else if (st == ST_PIXELS) begin
            if (pop && out_last) begin
               st         <= ST_DONE;
               write_done <= 1'b1;
            end
         end else if (vs_rise) begin
            st         <= ST_CAPTURE;
            write_done <= 1'b0;
            col        <= '0;
            row        <= '0;
            pair_cnt   <= '0;
            idx        <= '0;
            rd_word    <= '0;
            rd_lane    <= '0;
         end
      end
   end

   // Two-entry output skid: head drives the port, spare catches the in-flight byte during a stall
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         out_valid <= 1'b0;
         out_byte  <= '0;
         out_last  <= 1'b0;
         sp_v      <= 1'b0;
         sp_byte   <= '0;
         sp_last   <= 1'b0;
      end else begin
         if (pend) begin
            sp_byte <= in_byte;
            sp_last <= pend_last;
         end
         if (!out_valid || pop) begin
            out_valid <= sp_v || pend;
            out_byte  <= sp_v ? sp_byte : pend ? in_byte : out_byte;
            out_last  <= sp_v ? sp_last : pend && pend_last;
            sp_v      <= sp_v && pend;
         end else if (pend) begin
            sp_v <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_image_write.sv
// tb_image_write: scoreboard bench for the BMP frame writer on a 4x2 frame
module tb_image_write;

   localparam int W   = 4;
   localparam int H   = 2;
   localparam int IMG = W * H * 3;
   localparam int TOT = 54 + IMG;

   logic       HCLK = 1'b0;
   logic       HRESET, VSYNC, HSYNC, out_ready;
   logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
   logic [7:0] out_byte;
   logic       out_valid, out_last, write_done, drop_err;

   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         rx = 0;
   int         first_valid = -1;
   int         ready_mode = 0;
   int         stall_left = 0;
   bit         stall_done = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_byte = '0;
   logic [7:0] exp_q [$];

   always #5 HCLK = ~HCLK;

   image_write #(.WIDTH(W), .HEIGHT(H)) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .VSYNC      (VSYNC),
      .HSYNC      (HSYNC),
      .DATA_R0    (DATA_R0),
      .DATA_G0    (DATA_G0),
      .DATA_B0    (DATA_B0),
      .DATA_R1    (DATA_R1),
      .DATA_G1    (DATA_G1),
      .DATA_B1    (DATA_B1),
      .out_byte   (out_byte),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .write_done (write_done),
      .drop_err   (drop_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected BMP file: little-endian header fields, then rows bottom-up as B,G,R
   task automatic push_frame(input int base);
      logic [7:0] hdr [54];
      int offs [6] = '{2, 10, 14, 18, 22, 34};
      int vals [6] = '{54 + IMG, 54, 40, W, H, IMG};
      for (int i = 0; i < 54; i++) hdr[i] = 8'h00;
      hdr[0]  = 8'h42;
      hdr[1]  = 8'h4D;
      hdr[26] = 8'd1;
      hdr[28] = 8'd24;
      for (int f = 0; f < 6; f++)
         for (int b = 0; b < 4; b++) hdr[offs[f] + b] = 8'(vals[f] >> (8 * b));
      for (int i = 0; i < 54; i++) exp_q.push_back(hdr[i]);
      for (int r = H - 1; r >= 0; r--)
         for (int c = 0; c < W; c++) begin
            exp_q.push_back(8'(32 + base + r * W + c));
            exp_q.push_back(8'(16 + base + r * W + c));
            exp_q.push_back(8'(base + r * W + c));
         end
   endtask

   task automatic drive_pair(input int base, input int k);
      DATA_R0 = 8'(base + 2 * k);
      DATA_G0 = 8'(16 + base + 2 * k);
      DATA_B0 = 8'(32 + base + 2 * k);
      DATA_R1 = 8'(base + 2 * k + 1);
      DATA_G1 = 8'(16 + base + 2 * k + 1);
      DATA_B1 = 8'(32 + base + 2 * k + 1);
   endtask

   // One clock: sample at the falling edge, pick out_ready, score any byte the next rising edge accepts
   task automatic step();
      logic [7:0] e;
      @(negedge HCLK);
      cyc++;
      if (prev_stall) begin
         check("hold_valid", out_valid, 1);
         check("hold_byte", out_byte, prev_byte);
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 2) out_ready = 1'b0;
      else if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else if (rx == 10 && !stall_done) begin
         stall_done = 1;
         stall_left = 4;
         out_ready  = 1'b0;
      end else out_ready = ~out_ready;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("extra_byte", out_byte, 32'hFFFF_FFFF);
         else begin
            e = exp_q.pop_front();
            check($sformatf("byte_%0d", rx), out_byte, e);
            check($sformatf("last_%0d", rx), out_last, exp_q.size() == 0);
         end
         rx++;
      end
      prev_stall = ready_mode != 2 && out_valid && !out_ready;
      prev_byte  = out_byte;
   endtask

   task automatic run_frame(input int base, input int mode, input bit restart_mid, input bit inject, input int abort_at);
      int  t_last;
      bit  injected = 0;
      push_frame(base);
      ready_mode  = mode;
      rx          = 0;
      stall_done  = 0;
      first_valid = -1;
      VSYNC = 1'b1;
      step();
      VSYNC = 1'b0;
      check("wd_clear", write_done, 0);
      if (restart_mid)
         for (int k = 0; k < 3; k++) begin
            drive_pair(base + 64, k);
            HSYNC = 1'b1;
            step();
         end
      for (int k = 0; k < 4; k++) begin
         drive_pair(base, k);
         VSYNC = restart_mid && k == 0;
         HSYNC = 1'b1;
         step();
      end
      HSYNC  = 1'b0;
      VSYNC  = 1'b0;
      t_last = cyc;
      for (int i = 0; i < 1000 && !write_done && (abort_at == 0 || rx < abort_at); i++) begin
         if (inject && rx == 60 && !injected) begin
            injected = 1;
            HSYNC    = 1'b1;
            DATA_R0  = 8'hEE;
            step();
            HSYNC    = 1'b0;
         end else step();
      end
      check("first_byte_latency", first_valid, t_last + 1);
      if (abort_at == 0) begin
         check("write_done", write_done, 1);
         check("byte_count", rx, TOT);
         check("q_empty", exp_q.size(), 0);
         check("idle_valid", out_valid, 0);
      end
   endtask

   initial begin
      int         pos [12] = '{2, 3, 4, 5, 18, 19, 20, 21, 22, 23, 24, 25};
      logic [7:0] e768 [12] = '{8'h36, 8'h00, 8'h12, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
      HRESET = 1'b1;
      VSYNC  = 1'b0;
      HSYNC  = 1'b0;
      out_ready = 1'b1;
      drive_pair(0, 0);
      step();
      step();
      check("rst_byte", out_byte, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_done", write_done, 0);
      check("rst_drop", drop_err, 0);
      HRESET = 1'b0;

      for (int k = 0; k < 2; k++) begin
         drive_pair(128, k);
         HSYNC = 1'b1;
         step();
      end
      HSYNC = 1'b0;
      repeat (4) step();
      check("idle_valid", out_valid, 0);
      check("idle_drop", drop_err, 0);

      run_frame(0, 0, 0, 0, 0);
      run_frame(0, 1, 0, 0, 0);
      run_frame(8'h80, 0, 1, 0, 0);
      check("drop_before", drop_err, 0);
      run_frame(0, 0, 0, 1, 0);
      check("drop_after", drop_err, 1);

      run_frame(8'h50, 0, 0, 0, 30);
      ready_mode = 2;
      HRESET = 1'b1;
      step();
      step();
      exp_q.delete();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_byte", out_byte, 0);
      check("mid_rst_last", out_last, 0);
      check("mid_rst_done", write_done, 0);
      check("mid_rst_drop", drop_err, 0);
      HRESET = 1'b0;
      out_ready = 1'b1;
      run_frame(8'h33, 1, 0, 0, 0);

      for (int i = 0; i < 12; i++)
         check($sformatf("hdr768_%0d", pos[i]), image_pkg::bmp_hdr_byte(pos[i], 768, 512), e768[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
